// File: rtl/dmem_lsu_banked.sv
// rtl/dmem_lsu_banked.sv - byte-lane banked LSU data memory with valid/ready request and response
// DMEM_MISALIGN_TRAP_EN: misaligned accesses return err instead of being split into two beats.
module dmem_lsu_banked #(
  parameter int                ADDR_W    = 16,
  parameter int                MEM_BYTES = 8192,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h2000,
  parameter int                RD_LAT    = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wr,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [2:0]        i_req_funct3,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err
);
  localparam int WA_W  = $clog2(MEM_BYTES) - 2;
  localparam int WORDS = MEM_BYTES / 4;
  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 2);

`ifdef DMEM_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {IDLE, BEAT1, WAIT, RESP} state_t;
`else
  typedef enum logic [2:0] {IDLE, BEAT1, BEAT2, WAIT, RESP} state_t;
`endif
  state_t state, state_nxt;

  logic [7:0] bank [4][WORDS];

  logic [ADDR_W-1:0] off;
  logic [1:0]        a_lo, size;
  logic              illegal, out_of_range, dec_err;
  logic [7:0]        dec_mask;
  logic [63:0]       dec_wdata;
`ifndef DMEM_MISALIGN_TRAP_EN
  logic              need_split, dec_split;
`endif

  always_comb begin
    a_lo         = i_req_addr[1:0];
    size         = i_req_funct3[1:0];
    off          = i_req_addr - BASE_ADDR;
    out_of_range = (i_req_addr < BASE_ADDR) || (32'(off) >= 32'(MEM_BYTES));
    if (i_req_wr)
      illegal = i_req_funct3[2] || (size == 2'd3);
    else
      illegal = (i_req_funct3 == 3'd3) || (i_req_funct3[2:1] == 2'b11);
    dec_err = illegal || out_of_range;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((size == 2'd1 && a_lo[0]) || (size == 2'd2 && a_lo != 2'd0))
      dec_err = 1'b1;
`else
    need_split = (size == 2'd1 && a_lo == 2'd3) || (size == 2'd2 && a_lo != 2'd0);
    // beat 2 is never issued past the last word of the region
    dec_split  = need_split && !dec_err && !(&off[WA_W+1:2]);
`endif
    case (size)
      2'd0:    dec_mask = 8'h01;
      2'd1:    dec_mask = 8'h03;
      default: dec_mask = 8'h0f;
    endcase
    dec_mask = dec_mask << a_lo;
    if (dec_err || !i_req_wr)
      dec_mask = 8'h00;
    dec_wdata = {32'd0, i_req_wdata} << {a_lo, 3'b000};
  end

  logic            accept;
  logic [1:0]      a_q;
  logic [2:0]      f3_q;
  logic            wr_q, err_q;
  logic [WA_W-1:0] widx_q, rd_idx;
  logic [7:0]      mask_q;
  logic [63:0]     wdata_q;
  logic [1:0]      cnt_q, issue_tag;
`ifndef DMEM_MISALIGN_TRAP_EN
  logic            split_q;
  logic [WA_W-1:0] widx_hi;
  assign widx_hi = widx_q + WA_W'(1);
`endif

  assign o_req_ready = (state == IDLE) && !i_rst;
  assign accept      = i_req_valid && o_req_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = BEAT1;
      BEAT1: begin
        state_nxt = (RD_LAT > 1) ? WAIT : RESP;
`ifndef DMEM_MISALIGN_TRAP_EN
        if (split_q) state_nxt = BEAT2;
`endif
      end
`ifndef DMEM_MISALIGN_TRAP_EN
      BEAT2: state_nxt = (RD_LAT > 1) ? WAIT : RESP;
`endif
      WAIT:  if (cnt_q == WAIT_LAST) state_nxt = RESP;
      RESP:  if (o_rsp_valid && i_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_idx    = widx_q;
    issue_tag = 2'd0;
    if (state == BEAT1) issue_tag = 2'd1;
`ifndef DMEM_MISALIGN_TRAP_EN
    if (state == BEAT2) begin
      rd_idx    = widx_hi;
      issue_tag = 2'd2;
    end
`endif
  end

  // Read pipeline: each entry carries which beat its word belongs to.
  logic [31:0] pipe_data [RD_LAT];
  logic [1:0]  pipe_tag  [RD_LAT];
  logic [31:0] lat_data, lo_q, lo_word, hi_word, shifted, ld_result;
  logic [1:0]  lat_tag;

  always_ff @(posedge i_clk) begin
    if (accept) begin
      a_q     <= a_lo;
      f3_q    <= i_req_funct3;
      wr_q    <= i_req_wr;
      err_q   <= dec_err;
      widx_q  <= off[WA_W+1:2];
      mask_q  <= dec_mask;
      wdata_q <= dec_wdata;
`ifndef DMEM_MISALIGN_TRAP_EN
      split_q <= dec_split;
`endif
    end
    if (state == BEAT1 && !i_rst)
      for (int l = 0; l < 4; l++)
        if (mask_q[l]) bank[l][widx_q] <= wdata_q[8*l +: 8];
`ifndef DMEM_MISALIGN_TRAP_EN
    if (state == BEAT2 && !i_rst)
      for (int l = 0; l < 4; l++)
        if (mask_q[4+l]) bank[l][widx_hi] <= wdata_q[32+8*l +: 8];
`endif
    pipe_data[0] <= {bank[3][rd_idx], bank[2][rd_idx], bank[1][rd_idx], bank[0][rd_idx]};
    for (int i = 1; i < RD_LAT; i++)
      pipe_data[i] <= pipe_data[i-1];
    if (lat_tag == 2'd1)
      lo_q <= lat_data;
  end

  always_comb begin
    lat_data = pipe_data[RD_LAT-1];
    lat_tag  = pipe_tag[RD_LAT-1];
    lo_word  = (lat_tag == 2'd1) ? lat_data : lo_q;
    hi_word  = (lat_tag == 2'd2) ? lat_data : 32'd0;
    shifted  = 32'({hi_word, lo_word} >> {a_q, 3'b000});
    case (f3_q)
      3'd0:    ld_result = {{24{shifted[7]}}, shifted[7:0]};
      3'd4:    ld_result = {24'd0, shifted[7:0]};
      3'd1:    ld_result = {{16{shifted[15]}}, shifted[15:0]};
      3'd5:    ld_result = {16'd0, shifted[15:0]};
      3'd2:    ld_result = shifted;
      default: ld_result = 32'd0;
    endcase
    if (wr_q || err_q)
      ld_result = 32'd0;
  end

  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < RD_LAT; i++)
        pipe_tag[i] <= 2'd0;
      cnt_q       <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      pipe_tag[0] <= issue_tag;
      for (int i = 1; i < RD_LAT; i++)
        pipe_tag[i] <= pipe_tag[i-1];
      cnt_q <= (state == WAIT) ? cnt_q + 2'd1 : 2'd0;
      // First RESP cycle captures the last beat as it leaves the pipeline.
      if (state == RESP) begin
        if (!rsp_valid_q) begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= ld_result;
          rsp_err_q   <= err_q;
        end else if (i_rsp_ready) begin
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= 32'd0;
          rsp_err_q   <= 1'b0;
        end
      end
    end
  end

  assign o_rsp_valid = rsp_valid_q && !i_rst;
  assign o_rsp_rdata = i_rst ? 32'd0 : rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q && !i_rst;
endmodule

// File: tb/tb_dmem_lsu_banked.sv
// tb/tb_dmem_lsu_banked.sv - directed self-checking bench for dmem_lsu_banked
module tb_dmem_lsu_banked;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_wr = 1'b0, rsp_ready = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dmem_lsu_banked dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wr(req_wr),
    .i_req_addr(req_addr), .i_req_funct3(req_funct3), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err)
  );

  typedef struct packed {
    logic        wr;
    logic [2:0]  f3;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
    logic [3:0]  lat;
  } vec_t;

  function automatic vec_t mk(logic wr, logic [2:0] f3, logic [15:0] addr, logic [31:0] wd,
                              logic [31:0] rd, logic er, int lat);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd;
    v.rd = rd; v.er = er; v.lat = 4'(lat);
    return v;
  endfunction

  // Drives one request and handshakes its response; lat counts edges from acceptance to rsp_valid.
  task automatic xact(input logic wr, input logic [2:0] f3, input logic [15:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
    int n;
    req_valid = 1'b1; req_wr = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = rsp_rdata;
    er = rsp_err;
    if (rsp_valid === 1'b1) begin
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b rdata=%h err=%b, want 0 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic run_table(input string tag, input vec_t v[$]);
    logic [31:0] rd;
    logic        er;
    int          lat;
    for (int i = 0; i < v.size(); i++) begin
      xact(v[i].wr, v[i].f3, v[i].addr, v[i].wd, rd, er, lat);
      checks++;
      if (rd !== v[i].rd || er !== v[i].er || lat != int'(v[i].lat)) begin
        errors++;
        $display("FAIL %s[%0d] @%h: rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                 tag, i, v[i].addr, rd, er, lat, v[i].rd, v[i].er, v[i].lat);
      end
    end
  endtask

  task automatic test_sw_lw;
    vec_t v[$];
    v.push_back(mk(1'b1, 3'd2, 16'h2004, 32'hDEADBEEF, 32'h0, 1'b0, 2));
    v.push_back(mk(1'b0, 3'd2, 16'h2004, 32'h0,       32'hDEADBEEF, 1'b0, 2));
    run_table("sw_lw", v);
  endtask

  task automatic test_extend;
    vec_t v[$];
    v.push_back(mk(1'b1, 3'd2, 16'h2000, 32'h11223344, 32'h0, 1'b0, 2));
    v.push_back(mk(1'b0, 3'd0, 16'h2003, 32'h0, 32'h00000011, 1'b0, 2));
    v.push_back(mk(1'b0, 3'd4, 16'h2003, 32'h0, 32'h00000011, 1'b0, 2));
    v.push_back(mk(1'b0, 3'd1, 16'h2002, 32'h0, 32'h00001122, 1'b0, 2));
    v.push_back(mk(1'b0, 3'd5, 16'h2002, 32'h0, 32'h00001122, 1'b0, 2));
    v.push_back(mk(1'b1, 3'd0, 16'h2001, 32'h00000080, 32'h0, 1'b0, 2));
    v.push_back(mk(1'b0, 3'd0, 16'h2001, 32'h0, 32'hFFFFFF80, 1'b0, 2));
    v.push_back(mk(1'b0, 3'd4, 16'h2001, 32'h0, 32'h00000080, 1'b0, 2));
    v.push_back(mk(1'b0, 3'd1, 16'h2000, 32'h0, 32'hFFFF8044, 1'b0, 2));
    v.push_back(mk(1'b0, 3'd2, 16'h2000, 32'h0, 32'h11228044, 1'b0, 2));
    run_table("extend", v);
  endtask

  task automatic test_split;
    vec_t v[$];
    v.push_back(mk(1'b1, 3'd2, 16'h2008, 32'h55667788, 32'h0, 1'b0, 2));
    v.push_back(mk(1'b1, 3'd2, 16'h2006, 32'hA1B2C3D4, 32'h0, TRAP, TRAP ? 2 : 3));
    v.push_back(mk(1'b0, 3'd2, 16'h2006, 32'h0, TRAP ? 32'h0 : 32'hA1B2C3D4, TRAP, TRAP ? 2 : 3));
    v.push_back(mk(1'b0, 3'd2, 16'h2004, 32'h0, TRAP ? 32'hDEADBEEF : 32'hC3D4BEEF, 1'b0, 2));
    v.push_back(mk(1'b0, 3'd2, 16'h2008, 32'h0, TRAP ? 32'h55667788 : 32'h5566A1B2, 1'b0, 2));
    v.push_back(mk(1'b0, 3'd1, 16'h2007, 32'h0, TRAP ? 32'h0 : 32'hFFFFB2C3, TRAP, TRAP ? 2 : 3));
    v.push_back(mk(1'b0, 3'd5, 16'h2005, 32'h0, TRAP ? 32'h0 : 32'h0000D4BE, TRAP, 2));
    run_table("split", v);
  endtask

  task automatic test_range_illegal;
    vec_t v[$];
    v.push_back(mk(1'b0, 3'd2, 16'h1FFC, 32'h0, 32'h0, 1'b1, 2));
    v.push_back(mk(1'b1, 3'd2, 16'h0000, 32'hFFFFFFFF, 32'h0, 1'b1, 2));
    v.push_back(mk(1'b1, 3'd2, 16'h4000, 32'hFFFFFFFF, 32'h0, 1'b1, 2));
    v.push_back(mk(1'b0, 3'd3, 16'h2000, 32'h0, 32'h0, 1'b1, 2));
    v.push_back(mk(1'b1, 3'd4, 16'h2000, 32'h000000FF, 32'h0, 1'b1, 2));
    v.push_back(mk(1'b0, 3'd2, 16'h2000, 32'h0, 32'h11228044, 1'b0, 2));
    v.push_back(mk(1'b1, 3'd1, 16'h3FFE, 32'h0000BEEF, 32'h0, 1'b0, 2));
    v.push_back(mk(1'b0, 3'd2, 16'h3FFE, 32'h0, TRAP ? 32'h0 : 32'h0000BEEF, TRAP, 2));
    v.push_back(mk(1'b1, 3'd2, 16'h3FFE, 32'h12345678, 32'h0, TRAP, 2));
    v.push_back(mk(1'b0, 3'd5, 16'h3FFE, 32'h0, TRAP ? 32'h0000BEEF : 32'h00005678, 1'b0, 2));
    v.push_back(mk(1'b0, 3'd2, 16'h2000, 32'h0, 32'h11228044, 1'b0, 2));
    run_table("range", v);
  endtask

  task automatic test_backpressure;
    logic [31:0] rd;
    logic        er;
    int          n;
    req_valid = 1'b1; req_wr = 1'b0; req_funct3 = 3'd2; req_addr = 16'h2000;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL bp_latency: got %0d edges want 2", n);
    end
    // a competing store is offered while the response is held
    req_valid = 1'b1; req_wr = 1'b1; req_funct3 = 3'd2; req_addr = 16'h2010; req_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11228044 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b rdata=%h err=%b ready=%b, want 1 11228044 0 0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_handshake: valid=%b ready=%b, want 0 1", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: ready=%b want 0", req_ready);
    end
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != 2 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL bp_store_ack: lat=%0d err=%b rdata=%h, want 2 0 0", n, rsp_err, rsp_rdata);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    xact(1'b0, 3'd2, 16'h2010, 32'h0, rd, er, n);
    checks++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
      errors++;
      $display("FAIL bp_readback: rdata=%h err=%b, want CAFEF00D 0", rd, er);
    end
  endtask

  task automatic test_reset_midop;
    logic [31:0] rd;
    logic        er;
    int          n;
    bit          seen;
    xact(1'b1, 3'd2, 16'h2004, 32'h0, rd, er, n);
    xact(1'b1, 3'd2, 16'h2008, 32'h0, rd, er, n);
    req_valid = 1'b1; req_wr = 1'b1; req_funct3 = 3'd2; req_addr = 16'h2006; req_wdata = 32'hA1B2C3D4;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset_outputs: ready=%b valid=%b rdata=%h err=%b, want 0 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midop_ready_after: got %b want 1", req_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midop_dropped_rsp: response seen after reset, want none");
    end
    xact(1'b0, 3'd2, 16'h2004, 32'h0, rd, er, n);
    checks++;
    if (rd !== (TRAP ? 32'h0 : 32'hC3D40000) || er !== 1'b0) begin
      errors++;
      $display("FAIL midop_beat1_kept: rdata=%h err=%b, want %h 0", rd, er, TRAP ? 32'h0 : 32'hC3D40000);
    end
    xact(1'b0, 3'd2, 16'h2008, 32'h0, rd, er, n);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++;
      $display("FAIL midop_beat2_lost: rdata=%h err=%b, want 00000000 0", rd, er);
    end
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_extend();
    test_split();
    test_range_illegal();
    test_backpressure();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
endmodule
